midi_note_tracker: RTL

Upstream stage of midi_player. Consumes raw MIDI bytes from the UART receiver, parses channel voice messages and keeps a small last-note-priority stack of held notes. Drives midi_player's level-style interface: midi_data holds the current note number and midi_valid stays high while any note is held; amplitude follows velocity.

---
 rtl/midi_pkg.sv | 29 ++
 rtl/note_stack.sv | 80 ++++++++
 rtl/midi_note_tracker.sv | 138 +++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Constants and types shared by the MIDI note tracker and its note stack.
// Velocity storage exists only when MIDI_NOTE_TRACKER_VELOCITY_EN is defined.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [7:0] SYSEX_START      = 8'hF0;
  localparam logic [7:0] SYSEX_END        = 8'hF7;
  localparam logic [7:0] RT_MIN           = 8'hF8;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {P_IDLE, P_DATA1, P_DATA2, P_SYSEX} parser_state_t;

  typedef struct packed {
    logic [6:0] note;
`ifdef MIDI_NOTE_TRACKER_VELOCITY_EN
    logic [6:0] velocity;
`endif
  } note_entry_t;

  function automatic logic has_two_data_bytes(input logic [3:0] status_hi);
    return !(status_hi == PROG || status_hi == CHPRESS);
  endfunction

endpackage

// File: rtl/note_stack.sv
// Last-note-priority stack: index 0 is the oldest entry, count-1 the top.
// Push, remove and clear all complete in one cycle; next-state top/count are exported.
module note_stack
  import midi_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              remove_i,
  input  logic              clear_i,
  input  note_entry_t       entry_i,
  output note_entry_t       nxt_top_o,
  output logic [CNT_W-1:0]  nxt_count_o
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  note_entry_t      stack_q [DEPTH];
  note_entry_t      stack_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             hit, rem_en;
  logic [IDX_W-1:0] hit_idx, rem_idx;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && CNT_W'(i) < count_q && stack_q[i].note == entry_i.note) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end

    // A push either re-orders an existing entry or, when full, evicts the oldest.
    rem_en  = 1'b0;
    rem_idx = '0;
    if (push_i) begin
      rem_en  = hit || (count_q == FULL);
      rem_idx = hit ? hit_idx : '0;
    end else if (remove_i) begin
      rem_en  = hit;
      rem_idx = hit_idx;
    end

    stack_d = stack_q;
    count_d = count_q;
    if (rem_en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= rem_idx) stack_d[i] = stack_q[i + 1];
      end
      count_d = count_q - ONE;
    end
    if (push_i) begin
      stack_d[IDX_W'(count_d)] = entry_i;
      count_d = count_d + ONE;
    end
    if (clear_i) count_d = '0;
  end

  assign nxt_count_o = count_d;
  assign nxt_top_o   = (count_d == '0) ? '0 : stack_d[IDX_W'(count_d - ONE)];

  // NOTE: nonblocking assignments for all clocked state, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // NOTE: entry storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

endmodule

// File: rtl/midi_note_tracker.sv
// MIDI byte parser feeding a last-note-priority stack; outputs follow the top held note.
// Define MIDI_NOTE_TRACKER_VELOCITY_EN to make amplitude track the top note's velocity.
module midi_note_tracker
  import midi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [7:0]                   midi_data,
  output logic                         midi_valid,
  output logic [7:0]                   amplitude,
  output logic [$clog2(DEPTH+1)-1:0]   held_count,
  output logic                         note_event
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  parser_state_t    state_q;
  logic [7:0]       status_q;
  logic             rs_valid_q;
  logic [6:0]       data1_q;

  logic             is_rt, chan_ok, two_bytes;
  logic             push, remove, clear;
  note_entry_t      entry, nxt_top;
  logic [CNT_W-1:0] nxt_count;

  logic [7:0]       midi_data_q, midi_data_d, amplitude_q, amplitude_d;
  logic             midi_valid_q, midi_valid_d, note_event_q;
  logic [CNT_W-1:0] held_count_q;

  assign is_rt     = rx_data >= RT_MIN;
  assign two_bytes = has_two_data_bytes(status_q[7:4]);
  assign chan_ok   = (CHANNEL >= 16) || (status_q[3:0] == 4'(CHANNEL));

  // Stack commands are decoded from the byte that completes a two-byte message.
  always_comb begin
    push       = 1'b0;
    remove     = 1'b0;
    clear      = 1'b0;
    entry      = '0;
    entry.note = data1_q;
`ifdef MIDI_NOTE_TRACKER_VELOCITY_EN
    entry.velocity = rx_data[6:0];
`endif
    if (rx_valid && !rx_data[7] && state_q == P_DATA2 && chan_ok) begin
      case (status_q[7:4])
        NOTE_ON:  if (rx_data[6:0] != '0) push = 1'b1; else remove = 1'b1;
        NOTE_OFF: remove = 1'b1;
        CC:       clear  = (data1_q == CC_ALL_NOTES_OFF);
        default:  ;
      endcase
    end
  end

  note_stack #(.DEPTH(DEPTH)) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .remove_i    (remove),
    .clear_i     (clear),
    .entry_i     (entry),
    .nxt_top_o   (nxt_top),
    .nxt_count_o (nxt_count)
  );

  always_comb begin
    midi_valid_d = (nxt_count != '0);
    midi_data_d  = midi_valid_d ? {1'b0, nxt_top.note} : midi_data_q;
`ifdef MIDI_NOTE_TRACKER_VELOCITY_EN
    amplitude_d  = midi_valid_d ? {nxt_top.velocity, nxt_top.velocity[6]} : amplitude_q;
`else
    amplitude_d  = midi_valid_d ? 8'hFF : amplitude_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= P_IDLE;
      status_q     <= '0;
      rs_valid_q   <= 1'b0;
      data1_q      <= '0;
      midi_data_q  <= '0;
      midi_valid_q <= 1'b0;
      amplitude_q  <= '0;
      held_count_q <= '0;
      note_event_q <= 1'b0;
    end else begin
      if (rx_valid && !is_rt) begin
        if (rx_data[7]) begin
          if (rx_data == SYSEX_START) begin
            state_q    <= P_SYSEX;
            rs_valid_q <= 1'b0;
          end else if (rx_data > SYSEX_START) begin
            state_q    <= P_IDLE;
            rs_valid_q <= 1'b0;
          end else begin
            status_q   <= rx_data;
            rs_valid_q <= 1'b1;
            state_q    <= P_DATA1;
          end
        end else begin
          case (state_q)
            P_IDLE, P_DATA1: begin
              // In IDLE a data byte resumes the stored running status, if any.
              if (state_q == P_DATA1 || rs_valid_q) begin
                if (two_bytes) begin
                  data1_q <= rx_data[6:0];
                  state_q <= P_DATA2;
                end else begin
                  state_q <= P_IDLE;
                end
              end
            end
            P_DATA2: state_q <= P_IDLE;
            default: ;
          endcase
        end
      end
      midi_data_q  <= midi_data_d;
      midi_valid_q <= midi_valid_d;
      amplitude_q  <= amplitude_d;
      held_count_q <= nxt_count;
      note_event_q <= (midi_data_d != midi_data_q) || (midi_valid_d != midi_valid_q);
    end
  end

  assign midi_data  = midi_data_q;
  assign midi_valid = midi_valid_q;
  assign amplitude  = amplitude_q;
  assign held_count = held_count_q;
  assign note_event = note_event_q;

endmodule
